// File: rtl/reg_bus_master.sv
// reg_bus_master: turns command/byte-stream transactions into register bus strobes.
// One read byte is outstanding at a time; writes strobe one cycle after each accepted byte.
module reg_bus_master #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = 1
) (
    input  logic                     usb_clk,
    input  logic                     reset_n,
    input  logic                     I_cmd_valid,
    output logic                     O_cmd_ready,
    input  logic                     I_cmd_write,
    input  logic [7:0]               I_cmd_addr,
    input  logic [pBYTECNT_SIZE-1:0] I_cmd_len,
    input  logic [7:0]               I_wdata,
    input  logic                     I_wdata_valid,
    output logic                     O_wdata_ready,
    output logic [7:0]               O_rdata,
    output logic                     O_rdata_valid,
    input  logic                     I_rdata_ready,
    input  logic                     I_abort,
    output logic                     O_busy,
    output logic                     O_done,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    input  logic [7:0]               read_data
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, RWAIT, RHOLD, DONE} state_t;
    localparam logic [7:0] LAT = 8'(pREAD_LATENCY);

    state_t state, next;
    logic [pBYTECNT_SIZE-1:0] len_q, cnt;
    logic [7:0] lat;
    logic wr_q, abort_p, wdata_hs, lat_hit;

    assign O_cmd_ready   = state == IDLE;
    assign O_busy        = state != IDLE;
    // cnt counts accepted bytes; once it reaches len the last strobe is on the bus
    assign O_wdata_ready = state == WRITE && cnt != len_q && !I_abort;
    assign wdata_hs      = O_wdata_ready && I_wdata_valid;
    assign lat_hit       = state == RWAIT && lat == LAT;

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = I_cmd_valid ? SETUP : IDLE;
            SETUP: next = (I_abort || len_q == '0) ? DONE : wr_q ? WRITE : READ;
            WRITE: next = (I_abort || cnt == len_q) ? DONE : WRITE;
            READ:  next = I_abort ? DONE : RWAIT;
            RWAIT: next = lat_hit ? ((abort_p || I_abort) ? DONE : RHOLD) : RWAIT;
            RHOLD: next = I_abort ? DONE : !I_rdata_ready ? RHOLD : (cnt == len_q) ? DONE : READ;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            len_q         <= '0;
            cnt           <= '0;
            wr_q          <= 1'b0;
            lat           <= '0;
            abort_p       <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            write_data    <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            O_rdata       <= '0;
            O_rdata_valid <= 1'b0;
            O_done        <= 1'b0;
        end else begin
            state         <= next;
            reg_write     <= wdata_hs;
            reg_read      <= next == READ;
            reg_addrvalid <= next != IDLE && next != DONE;
            O_rdata_valid <= next == RHOLD;
            O_done        <= next == DONE;
            if (state == IDLE && I_cmd_valid) begin
                reg_address <= I_cmd_addr;
                reg_bytecnt <= '0;
                len_q       <= I_cmd_len;
                wr_q        <= I_cmd_write;
                cnt         <= '0;
            end
            if (wdata_hs) begin
                write_data  <= I_wdata;
                reg_bytecnt <= cnt;
                cnt         <= cnt + 1'b1;
            end
            if (next == READ)
                reg_bytecnt <= cnt;
            lat     <= state == READ ? 8'd1 : lat + 8'd1;
            abort_p <= state == RWAIT && (abort_p || I_abort);
            if (lat_hit) begin
                O_rdata <= read_data;
                cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed vectors for reg_bus_master against a ROM read model
// and a write-strobe log, with hand-computed expectations.
module tb_reg_bus_master;
    logic       clk = 0, reset_n = 0;
    logic       I_cmd_valid = 0, I_cmd_write = 0, I_wdata_valid = 0, I_rdata_ready = 0, I_abort = 0;
    logic [7:0] I_cmd_addr = 0, I_wdata = 0, read_data = 0;
    logic [6:0] I_cmd_len = 0;
    logic       O_cmd_ready, O_wdata_ready, O_rdata_valid, O_busy, O_done;
    logic       reg_read, reg_write, reg_addrvalid;
    logic [7:0] O_rdata, reg_address, write_data;
    logic [6:0] reg_bytecnt;

    int total = 0, bad = 0;
    int nw = 0, nr = 0, ndone = 0, nboth = 0, cyc = 0;
    logic [7:0] w_addr [64], w_data [64], rbuf [16];
    logic [6:0] w_cnt [64];
    logic       w_av [64];
    int         w_cyc [64];
    logic [7:0] rom [256];

    reg_bus_master dut (
        .usb_clk(clk), .reset_n(reset_n),
        .I_cmd_valid(I_cmd_valid), .O_cmd_ready(O_cmd_ready), .I_cmd_write(I_cmd_write),
        .I_cmd_addr(I_cmd_addr), .I_cmd_len(I_cmd_len),
        .I_wdata(I_wdata), .I_wdata_valid(I_wdata_valid), .O_wdata_ready(O_wdata_ready),
        .O_rdata(O_rdata), .O_rdata_valid(O_rdata_valid), .I_rdata_ready(I_rdata_ready),
        .I_abort(I_abort), .O_busy(O_busy), .O_done(O_done),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    // register block model: one cycle read latency
    always @(posedge clk)
        if (reg_read) read_data <= rom[8'(reg_address + 8'(reg_bytecnt))];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reg_read) nr <= nr + 1;
        if (O_done) ndone <= ndone + 1;
        if (reg_read && reg_write) nboth <= nboth + 1;
        if (reg_write && nw < 64) begin
            w_addr[nw] <= reg_address;
            w_data[nw] <= write_data;
            w_cnt[nw]  <= reg_bytecnt;
            w_av[nw]   <= reg_addrvalid;
            w_cyc[nw]  <= cyc;
            nw         <= nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [6:0] len);
        @(negedge clk);
        I_cmd_valid = 1; I_cmd_write = wr; I_cmd_addr = addr; I_cmd_len = len;
        @(posedge clk);
        #1 I_cmd_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
            I_wdata_valid = 0; I_rdata_ready = 0; I_abort = 0;
        end while (!O_done && c < 100);
        chk(tag, O_done, 1);
        @(negedge clk);
        chk({tag, "_idle"}, {O_cmd_ready, O_busy, O_done, reg_addrvalid}, 4'b1000);
    endtask

    task automatic wr_bytes(input int n, input bit gap, input int abort_at);
        int i = 0, c = 0;
        while (i < n && c < 200) begin
            @(negedge clk);
            c++;
            if (i == abort_at) begin
                I_abort = 1; I_wdata_valid = 1;
                break;
            end
            I_wdata = 8'((i + 1) * 8'h11);
            I_wdata_valid = gap ? (c % 2 == 0) : 1'b1;
            #1 if (I_wdata_valid && O_wdata_ready) i++;
        end
        chk("wr_budget", c < 200, 1);
    endtask

    task automatic rd_bytes(input int n, input int stall_at);
        int k = 0, hold = 0, c = 0;
        logic [7:0] held = 0;
        while (k < n && c < 300) begin
            @(negedge clk);
            c++;
            I_rdata_ready = 0;
            if (O_rdata_valid) begin
                if (k == stall_at && hold < 5) begin
                    if (hold > 0) chk("rd_hold_stable", O_rdata, held);
                    held = O_rdata;
                    hold++;
                end else begin
                    rbuf[k] = O_rdata;
                    k++;
                    I_rdata_ready = 1;
                end
            end
        end
        chk("rd_budget", c < 300, 1);
    endtask

    initial begin
        int nw0, nr0, nd0;
        logic [7:0] name [8];
        name = '{8'h41, 8'h72, 8'h6d, 8'h54, 8'h72, 8'h61, 8'h63, 8'h65};
        for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? name[i] : 8'h00;

        #1;
        chk("reset_outs", {reg_read, reg_write, reg_addrvalid, O_rdata_valid, O_done, O_busy,
                           reg_address, reg_bytecnt, write_data, O_rdata}, 0);
        chk("reset_ready", O_cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset_n = 1;

        // single-byte write, cycle by cycle
        I_wdata = 8'h03; I_wdata_valid = 1;
        send_cmd(1, 8'h05, 1);
        @(negedge clk);
        chk("w1_setup", {O_busy, O_cmd_ready, reg_addrvalid, reg_write, reg_read, O_wdata_ready}, 6'b101000);
        chk("w1_setup_addr", {reg_address, reg_bytecnt}, {8'h05, 7'd0});
        @(negedge clk);
        chk("w1_wready", {O_wdata_ready, reg_write}, 2'b10);
        @(negedge clk);
        I_wdata_valid = 0;
        chk("w1_strobe", {reg_write, reg_read, reg_addrvalid, O_done}, 4'b1010);
        chk("w1_bus", {reg_address, reg_bytecnt, write_data}, {8'h05, 7'd0, 8'h03});
        @(negedge clk);
        chk("w1_done", {O_done, reg_write, reg_addrvalid, O_busy}, 4'b1001);
        @(negedge clk);
        chk("w1_idle", {O_done, O_cmd_ready, O_busy}, 3'b010);

        // 8-byte gapped write
        nw0 = nw;
        send_cmd(1, 8'h20, 8);
        wr_bytes(8, 1, -1);
        wait_done("w8_done");
        chk("w8_count", nw - nw0, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w8_cnt%0d", i), w_cnt[nw0 + i], 7'(i));
            chk($sformatf("w8_data%0d", i), w_data[nw0 + i], 8'((i + 1) * 8'h11));
            chk($sformatf("w8_addr%0d", i), {w_av[nw0 + i], w_addr[nw0 + i]}, {1'b1, 8'h20});
            if (i > 0) chk($sformatf("w8_gap%0d", i), w_cyc[nw0 + i] - w_cyc[nw0 + i - 1], 2);
        end

        // 8-byte read of the name bytes, stalling byte 2
        nr0 = nr;
        send_cmd(0, 8'h00, 8);
        rd_bytes(8, 2);
        wait_done("r8_done");
        for (int i = 0; i < 8; i++) chk($sformatf("r8_byte%0d", i), rbuf[i], name[i]);
        chk("r8_reads", nr - nr0, 8);

        // zero-length command
        nr0 = nr; nw0 = nw;
        send_cmd(0, 8'h07, 0);
        @(negedge clk);
        chk("len0_setup", {reg_addrvalid, O_busy, O_done}, 3'b110);
        @(negedge clk);
        chk("len0_done", {reg_addrvalid, O_done}, 2'b01);
        @(negedge clk);
        chk("len0_strobes", {32'(nr - nr0), 32'(nw - nw0)}, 0);
        chk("len0_idle", O_cmd_ready, 1);

        // abort during byte 3 of an 8-byte write
        nw0 = nw;
        send_cmd(1, 8'h40, 8);
        wr_bytes(8, 0, 3);
        wait_done("abort_done");
        chk("abort_strobes", nw - nw0, 3);
        chk("abort_last_cnt", w_cnt[nw0 + 2], 7'd2);

        // reset mid-read
        nd0 = ndone;
        send_cmd(0, 8'h03, 5);
        repeat (4) @(negedge clk);
        chk("mid_busy", {O_busy, reg_addrvalid, reg_address}, {2'b11, 8'h03});
        #2 reset_n = 0;
        #1;
        chk("mid_reset_outs", {reg_read, reg_write, reg_addrvalid, O_rdata_valid, O_done, O_busy,
                               reg_address, reg_bytecnt, write_data, O_rdata}, 0);
        @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        chk("mid_no_done", ndone - nd0, 0);
        send_cmd(0, 8'h06, 2);
        rd_bytes(2, -1);
        wait_done("post_done");
        chk("post_byte0", rbuf[0], 8'h63);
        chk("post_byte1", rbuf[1], 8'h65);
        chk("never_both", nboth, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
